// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - load/store initiator between execute stage and word-organised data memory
//
// Purpose: accepts one RISC-V load/store per request handshake, issues
// word-aligned memory reads/writes, extends load data, merges sub-word
// stores via read-modify-write, and flags misaligned or illegal ops.
//
// Ports:
//   clk_i, reset_i                      clock, async active-high reset
//   req_valid_i/req_ready_o             request handshake
//   req_write_i, req_funct3_i           store select, RISC-V funct3
//   req_addr_i, req_wdata_i             byte address, store data
//   resp_valid_o/resp_ready_i           response handshake
//   resp_rdata_o, resp_err_o            extended load data, error flag
//   mem_addr_o, mem_read_o, mem_write_o word address and strobes
//   mem_wdata_o, mem_rdata_i            memory write / read data

module load_store_unit #(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_write_i,
  input  logic [2:0]            req_funct3_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [31:0]           req_wdata_i,
  output logic                  resp_valid_o,
  input  logic                  resp_ready_i,
  output logic [31:0]           resp_rdata_o,
  output logic                  resp_err_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic                  mem_read_o,
  output logic [31:0]           mem_wdata_o,
  output logic                  mem_write_o,
  input  logic [31:0]           mem_rdata_i
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [2:0]              funct3_q, funct3_d;
  logic                    write_q, write_d;
  logic [31:0]             wdata_q, wdata_d;
  logic [31:0]             word_q, word_d;
  logic [31:0]             rdata_q, rdata_d;
  logic                    err_q, err_d;

  logic                    req_illegal;
  logic                    req_misaligned;
  logic [7:0]              sel_byte;
  logic [15:0]             sel_half;
  logic [31:0]             load_val;
  logic [31:0]             merged;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      funct3_q <= '0;
      write_q  <= 1'b0;
      wdata_q  <= '0;
      word_q   <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      funct3_q <= funct3_d;
      write_q  <= write_d;
      wdata_q  <= wdata_d;
      word_q   <= word_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // Request decode: stores only have B/H/W, loads add BU/HU.
  always_comb begin
    req_illegal = 1'b1;
    case (req_funct3_i)
      F3_B, F3_H, F3_W: req_illegal = 1'b0;
      F3_BU, F3_HU:     req_illegal = req_write_i;
      default:          req_illegal = 1'b1;
    endcase
    req_misaligned = ((req_funct3_i[1:0] == 2'b01) && req_addr_i[0]) ||
                     ((req_funct3_i[1:0] == 2'b10) && (req_addr_i[1:0] != 2'b00));
  end

  // Lane selection on the live memory read data and extension per funct3.
  always_comb begin
    sel_byte = mem_rdata_i[7:0];
    case (addr_q[1:0])
      2'd0: sel_byte = mem_rdata_i[7:0];
      2'd1: sel_byte = mem_rdata_i[15:8];
      2'd2: sel_byte = mem_rdata_i[23:16];
      2'd3: sel_byte = mem_rdata_i[31:24];
      default: sel_byte = mem_rdata_i[7:0];
    endcase
    sel_half = addr_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
    load_val = mem_rdata_i;
    case (funct3_q)
      F3_B:    load_val = {{24{sel_byte[7]}}, sel_byte};
      F3_H:    load_val = {{16{sel_half[15]}}, sel_half};
      F3_BU:   load_val = {24'h0, sel_byte};
      F3_HU:   load_val = {16'h0, sel_half};
      default: load_val = mem_rdata_i;
    endcase
  end

  // Sub-word store merge into the word captured during READ.
  always_comb begin
    merged = word_q;
    if (funct3_q == F3_B) begin
      case (addr_q[1:0])
        2'd0: merged[7:0]   = wdata_q[7:0];
        2'd1: merged[15:8]  = wdata_q[7:0];
        2'd2: merged[23:16] = wdata_q[7:0];
        2'd3: merged[31:24] = wdata_q[7:0];
        default: merged = word_q;
      endcase
    end else if (funct3_q == F3_H) begin
      if (addr_q[1]) merged[31:16] = wdata_q[15:0];
      else           merged[15:0]  = wdata_q[15:0];
    end else begin
      merged = wdata_q;
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    funct3_d     = funct3_q;
    write_d      = write_q;
    wdata_d      = wdata_q;
    word_d       = word_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    req_ready_o  = 1'b0;
    resp_valid_o = 1'b0;
    mem_read_o   = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = '0;
    mem_wdata_o  = '0;

    case (state_q)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          addr_d   = req_addr_i;
          funct3_d = req_funct3_i;
          write_d  = req_write_i;
          wdata_d  = req_wdata_i;
          rdata_d  = '0;
          err_d    = 1'b0;
          if (req_illegal || req_misaligned) begin
            err_d   = 1'b1;
            state_d = RESP;
          end else if (req_write_i && (req_funct3_i == F3_W)) begin
            state_d = WRITE;
          end else begin
            state_d = READ;
          end
        end
      end
      READ: begin
        mem_read_o = 1'b1;
        mem_addr_o = {addr_q[ADDR_WIDTH-1:2], 2'b00};
        word_d     = mem_rdata_i;
        if (write_q) begin
          state_d = WRITE;
        end else begin
          rdata_d = load_val;
          state_d = RESP;
        end
      end
      WRITE: begin
        mem_write_o = 1'b1;
        mem_addr_o  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
        mem_wdata_o = merged;
        state_d     = RESP;
      end
      RESP: begin
        resp_valid_o = 1'b1;
        if (resp_ready_i) begin
          rdata_d = '0;
          err_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign resp_rdata_o = rdata_q;
  assign resp_err_o   = err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit

module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic        mem_read;
  logic [31:0] mem_wdata;
  logic        mem_write;
  logic [31:0] mem_rdata;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] mem [0:15] = '{4: 32'h8899AABB, 6: 32'h01020304, 8: 32'h8899AABB, default: 32'h0};

  int          rd_cnt = 0;
  int          wr_cnt = 0;
  int          overlap_cnt = 0;
  logic [31:0] last_addr = 32'h0;
  logic [31:0] last_wdata = 32'h0;

  load_store_unit #(.ADDR_WIDTH(32)) dut (
    .clk_i(clk), .reset_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_write_i(req_write), .req_funct3_i(req_funct3),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
    .resp_rdata_o(resp_rdata), .resp_err_o(resp_err),
    .mem_addr_o(mem_addr), .mem_read_o(mem_read),
    .mem_wdata_o(mem_wdata), .mem_write_o(mem_write),
    .mem_rdata_i(mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[5:2]];

  always @(posedge clk) begin
    if (mem_write) begin
      mem[mem_addr[5:2]] <= mem_wdata;
      wr_cnt     <= wr_cnt + 1;
      last_addr  <= mem_addr;
      last_wdata <= mem_wdata;
    end
    if (mem_read) begin
      rd_cnt    <= rd_cnt + 1;
      last_addr <= mem_addr;
    end
    if (mem_read && mem_write) overlap_cnt <= overlap_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic run(input string tag, input bit wr, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] exp_rdata, input bit exp_err,
                     input int exp_lat, input int exp_rd, input int exp_wr,
                     input int hold);
    int rd0, wr0, lat;
    @(negedge clk);
    chk({tag, " req_ready idle"}, {31'h0, req_ready}, 32'd1);
    resp_ready = (hold == 0);
    req_valid  = 1'b1;
    req_write  = wr;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, " latency"}, lat, exp_lat);
    chk({tag, " rdata"}, resp_rdata, exp_rdata);
    chk({tag, " err"}, {31'h0, resp_err}, {31'h0, exp_err});
    chk({tag, " req_ready busy"}, {31'h0, req_ready}, 32'd0);
    chk({tag, " strobes in resp"}, {30'h0, mem_read, mem_write}, 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk({tag, " hold valid"}, {31'h0, resp_valid}, 32'd1);
      chk({tag, " hold rdata"}, resp_rdata, exp_rdata);
      chk({tag, " hold req_ready"}, {31'h0, req_ready}, 32'd0);
      chk({tag, " hold strobes"}, {30'h0, mem_read, mem_write}, 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk({tag, " resp done"}, {31'h0, resp_valid}, 32'd0);
    chk({tag, " req_ready after"}, {31'h0, req_ready}, 32'd1);
    chk({tag, " read count"}, rd_cnt - rd0, exp_rd);
    chk({tag, " write count"}, wr_cnt - wr0, exp_wr);
    if (exp_rd + exp_wr > 0)
      chk({tag, " mem_addr"}, last_addr, {addr[31:2], 2'b00});
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    resp_ready = 1'b1;
    #1;
    chk("reset req_ready", {31'h0, req_ready}, 32'd1);
    chk("reset resp_valid", {31'h0, resp_valid}, 32'd0);
    chk("reset resp_rdata", resp_rdata, 32'h0);
    chk("reset resp_err", {31'h0, resp_err}, 32'd0);
    chk("reset strobes", {30'h0, mem_read, mem_write}, 32'd0);
    chk("reset mem_addr", mem_addr, 32'h0);
    chk("reset mem_wdata", mem_wdata, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Loads from word 0x10 = 0x8899AABB
    run("LB 0x11",  1'b0, 3'b000, 32'h11, 32'h0, 32'hFFFFFFAA, 1'b0, 2, 1, 0, 0);
    run("LBU 0x13", 1'b0, 3'b100, 32'h13, 32'h0, 32'h00000088, 1'b0, 2, 1, 0, 0);
    run("LBU 0x12", 1'b0, 3'b100, 32'h12, 32'h0, 32'h00000099, 1'b0, 2, 1, 0, 0);
    run("LH 0x12",  1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFF8899, 1'b0, 2, 1, 0, 0);
    run("LHU 0x10", 1'b0, 3'b101, 32'h10, 32'h0, 32'h0000AABB, 1'b0, 2, 1, 0, 0);
    run("LW 0x10",  1'b0, 3'b010, 32'h10, 32'h0, 32'h8899AABB, 1'b0, 2, 1, 0, 0);

    // Stores
    run("SB 0x12", 1'b1, 3'b000, 32'h12, 32'h12345655, 32'h0, 1'b0, 3, 1, 1, 0);
    chk("SB wdata", last_wdata, 32'h8855AABB);
    chk("SB mem", mem[4], 32'h8855AABB);
    run("SH 0x20", 1'b1, 3'b001, 32'h20, 32'h0000CAFE, 32'h0, 1'b0, 3, 1, 1, 0);
    chk("SH wdata", last_wdata, 32'h8899CAFE);
    chk("SH mem", mem[8], 32'h8899CAFE);
    run("SW 0x14", 1'b1, 3'b010, 32'h14, 32'hDEADBEEF, 32'h0, 1'b0, 2, 0, 1, 0);
    chk("SW mem", mem[5], 32'hDEADBEEF);

    // Errors: no memory access, one-cycle response
    run("LW 0x12 mis",  1'b0, 3'b010, 32'h12, 32'h0, 32'h0, 1'b1, 1, 0, 0, 0);
    run("SH 0x11 mis",  1'b1, 3'b001, 32'h11, 32'hFFFF, 32'h0, 1'b1, 1, 0, 0, 0);
    run("ld f3 011",    1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1, 1, 0, 0, 0);
    run("st f3 100",    1'b1, 3'b100, 32'h10, 32'h0, 32'h0, 1'b1, 1, 0, 0, 0);
    chk("mem after err", mem[4], 32'h8855AABB);

    // Response back-pressure: ready low for 3 response cycles
    run("LW hold", 1'b0, 3'b010, 32'h10, 32'h0, 32'h8855AABB, 1'b0, 2, 1, 0, 3);

    // Reset during the WRITE phase of an SB
    @(negedge clk);
    req_valid  = 1'b1;
    req_write  = 1'b1;
    req_funct3 = 3'b000;
    req_addr   = 32'h18;
    req_wdata  = 32'h000000AA;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("rst-SB in READ", {31'h0, mem_read}, 32'd1);
    @(posedge clk);
    #1;
    chk("rst-SB in WRITE", {31'h0, mem_write}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst mem_write drop", {31'h0, mem_write}, 32'd0);
    chk("rst req_ready", {31'h0, req_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst word unchanged", mem[6], 32'h01020304);
    chk("rst resp_valid", {31'h0, resp_valid}, 32'd0);
    chk("rst req_ready after", {31'h0, req_ready}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("rst no response", {31'h0, resp_valid}, 32'd0);

    // Unit still works after the abort
    run("LW 0x18 post", 1'b0, 3'b010, 32'h18, 32'h0, 32'h01020304, 1'b0, 2, 1, 0, 0);
    chk("no read/write overlap", overlap_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
